spad_byte_packer: RTL
=====================

Name: spad_byte_packer

Overview:
- Sits between the SPAD envelope bit extractor and the USB CDC IN endpoint.
- Serialises the extractor's env_bit/env_valid stream into 8-bit bytes and buffers them in a small FIFO.
- Presents the bytes on a valid/ready interface to the CDC in_data/in_valid/in_ready port.
- Drops whole bytes on overflow; reports drops through a sticky flag and a saturating counter.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of two, minimum 2.
- MSB_FIRST, 0, 0 = first received bit lands in data[0]; 1 = first received bit lands in data[7].
- DROP_CNT_W, 8, width of the saturating dropped-byte counter.

Ports:
- clk  input  1  system clock, 48 MHz, same clock as the CDC core and the extractor.
- rst_n  input  1  asynchronous active-low reset.
- enable_i  input  1  packing enable; while low, incoming bits are ignored.
- clr_i  input  1  synchronous one-cycle clear of overflow_o and drop_cnt_o.
- env_bit_i  input  1  envelope bit from the extractor.
- env_valid_i  input  1  one-cycle strobe qualifying env_bit_i.
- in_data_o  output  8  byte to the CDC IN endpoint.
- in_valid_o  output  1  in_data_o is valid.
- in_ready_i  input  1  CDC accepts the byte this cycle.
- overflow_o  output  1  sticky; a byte was dropped.
- drop_cnt_o  output  DROP_CNT_W  count of dropped bytes, saturating.
- level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (async, rst_n low): bit counter 0, shift register 0, FIFO empty, in_valid_o 0, in_data_o 0, overflow_o 0, drop_cnt_o 0, level_o 0.
- Bit capture:
  - A bit is captured on a clk edge where env_valid_i=1 and enable_i=1.
  - The 3-bit counter increments on each capture.
  - Bit placement follows MSB_FIRST.
- Byte completion:
  - On the 8th capture (counter==7), the assembled byte, including the current env_bit_i, is pushed to the FIFO on that same edge.
  - The counter wraps to 0 on that edge.
- enable_i deassertion:
  - enable_i low for any cycle resets the counter to 0 and discards the partial byte.
  - FIFO contents are kept and continue to drain.
- Push rule:
  - Push is accepted if the FIFO is not full, or if it is full and a pop occurs on the same edge.
  - Otherwise the byte is dropped: overflow_o is set, and drop_cnt_o increments, saturating at all-ones.
- clr_i:
  - clr_i=1 clears overflow_o and drop_cnt_o.
  - If clr_i coincides with a drop, clear wins and the drop is not counted.
- Output handshake:
  - in_valid_o = FIFO not empty (registered occupancy).
  - in_data_o = head entry; it is held stable while in_valid_o=1 and in_ready_i=0.
  - A pop happens on an edge where in_valid_o=1 and in_ready_i=1.
  - in_ready_i is ignored when the FIFO is empty.
- Latency: the byte appears on in_data_o with in_valid_o=1 one cycle after the edge that captured its 8th bit, when the FIFO was empty.
- Simultaneous push and pop on a non-empty FIFO: level_o is unchanged and ordering is preserved.
- Pointers wrap modulo FIFO_DEPTH; full/empty are derived from level.
- The block makes no assumption about env_valid_i spacing; back-to-back strobes every cycle must be sustained.

Decomposition:
- Package spad_pkg:
  - SPAD_BYTE_W = 8.
  - typedef spad_byte_t (logic [7:0]).
  - Shared with the extractor's future config.
- Sub-module byte_fifo:
  - Parameterised width/depth synchronous FIFO with push/pop/full/empty/level.
  - Async active-low reset on pointers and level only.
  - Storage registers are not reset.
- Top spad_byte_packer holds the shift/count logic and the overflow accounting.

Test Plan:
- Packing, LSB first: MSB_FIRST=0, enable_i=1, bits 1,0,1,0,0,1,0,1 on consecutive env_valid_i, in_ready_i=1 -> in_data_o=8'hA5, in_valid_o high exactly one cycle, starting the cycle after the 8th strobe.
- Packing, MSB first: MSB_FIRST=1, same bit sequence -> in_data_o=8'hA5 bit-reversed = 8'hA5 (palindrome); repeat with 1,1,0,0,0,0,0,0 -> 8'hC0.
- Partial-byte discard: send 5 bits, drop enable_i for 1 cycle, re-enable, send 8 bits 0xFF pattern -> only one byte, 8'hFF, emitted; level_o peaks at 1.
- Backpressure and overflow: in_ready_i=0, push 6 bytes 0x01..0x06 with FIFO_DEPTH=4 -> level_o=4, overflow_o=1, drop_cnt_o=2; release in_ready_i -> bytes 0x01..0x04 out in order, data stable throughout the stall.
- Full with simultaneous pop: FIFO full, in_ready_i=1 on the edge the next byte completes -> no drop, drop_cnt_o unchanged, level_o stays 4.
- Clear and reset: after drops, pulse clr_i -> overflow_o=0, drop_cnt_o=0. Separately, assert rst_n low mid-byte with 3 bytes queued -> all outputs at reset values; the next 8 bits form a fresh byte.

Source files
------------

// File: rtl/spad_pkg.sv
// Shared SPAD byte definitions. The packer uses them today; the envelope
// extractor's configuration will import the same package later.
package spad_pkg;

   localparam int SPAD_BYTE_W = 8;

   typedef logic [SPAD_BYTE_W-1:0] spad_byte_t;

endpackage : spad_pkg

// File: rtl/byte_fifo.sv
// Synchronous width/depth FIFO. Pointers and level are reset; storage is not.
// The read port returns zero while empty, so the head never exposes stale data.
module byte_fifo
   import spad_pkg::*;
#(
   parameter  int WIDTH = SPAD_BYTE_W,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;

   // A full FIFO still takes a push when the head leaves on the same edge.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_comb begin
      level_d = level_q;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         level_q <= level_d;
      end
   end

endmodule : byte_fifo

// File: rtl/spad_byte_packer.sv
// Packs the extractor's env_bit/env_valid stream into bytes and queues them
// for the CDC IN endpoint; bytes that find the queue full are dropped and counted.
module spad_byte_packer
   import spad_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   parameter  bit MSB_FIRST  = 1'b0,
   parameter  int DROP_CNT_W = 8,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable_i,
   input  logic                  clr_i,
   input  logic                  env_bit_i,
   input  logic                  env_valid_i,
   output logic [7:0]            in_data_o,
   output logic                  in_valid_o,
   input  logic                  in_ready_i,
   output logic                  overflow_o,
   output logic [DROP_CNT_W-1:0] drop_cnt_o,
   output logic [LVL_W-1:0]      level_o
);

   logic [2:0]            cnt_q;
   logic [2:0]            cnt_d;
   spad_byte_t            sr_q;
   spad_byte_t            sr_d;
   spad_byte_t            shifted;
   logic                  overflow_q;
   logic                  overflow_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q;
   logic [DROP_CNT_W-1:0] drop_cnt_d;
   logic                  capture;
   logic                  byte_done;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  pop;
   logic                  push_ok;
   logic                  drop;

   assign capture   = env_valid_i && enable_i;
   assign byte_done = capture && (cnt_q == 3'd7);

   // Shifting toward the far end means the first bit finishes at data[0]
   // (LSB first) or data[7] (MSB first); after 8 captures the shifted value
   // is the complete byte, including the bit arriving this cycle.
   assign shifted = MSB_FIRST ? {sr_q[6:0], env_bit_i} : {env_bit_i, sr_q[7:1]};

   // Handshake: a byte transfers on every edge where in_valid_o and in_ready_i
   // are both high; in_data_o holds while in_valid_o is high and in_ready_i low,
   // and in_ready_i has no effect while in_valid_o is low.
   assign in_valid_o = !fifo_empty;
   assign pop        = in_valid_o && in_ready_i;
   assign push_ok    = !fifo_full || pop;
   assign drop       = byte_done && !push_ok;

   always_comb begin
      cnt_d = cnt_q;
      sr_d  = sr_q;
      if (!enable_i) begin
         cnt_d = '0;
         sr_d  = '0;
      end else if (env_valid_i) begin
         cnt_d = cnt_q + 3'd1;
         sr_d  = shifted;
      end
   end

   always_comb begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (clr_i) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         sr_q       <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign overflow_o = overflow_q;
   assign drop_cnt_o = drop_cnt_q;

   byte_fifo #(
      .WIDTH (SPAD_BYTE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (byte_done),
      .pop_i   (pop),
      .wdata_i (shifted),
      .rdata_o (in_data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_o)
   );

endmodule : spad_byte_packer
